// File: rtl/apb_slave_regs.sv
// APB completer with a byte-wide register file, programmable wait states,
// out-of-range error responses and a saturating error counter.
module apb_slave_regs #(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_DEPTH   = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic                  pclk,
  input  logic                  prst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [7:0]            err_cnt
);

  typedef enum logic [1:0] {
    SLAVE_IDLE  = 2'd0,
    SLAVE_WRITE = 2'd1,
    SLAVE_READ  = 2'd2
  } apb_slave_state_t;

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  apb_slave_state_t      state_reg, state_next;
  logic [3:0]            wait_cnt_reg, wait_cnt_next;
  logic [IDX_W-1:0]      addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic                  err_reg;
  logic [7:0]            err_cnt_reg;
  logic                  setup;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  assign setup = (state_reg == SLAVE_IDLE) && psel && !penable;

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    pready        = 1'b0;
    case (state_reg)
      SLAVE_IDLE: begin
        if (setup) begin
          wait_cnt_next = 4'(WAIT_STATES);
          state_next    = pwrite ? SLAVE_WRITE : SLAVE_READ;
        end
      end
      SLAVE_WRITE, SLAVE_READ: begin
        // Dropping psel mid-transfer abandons it with no side effects.
        if (!psel) begin
          state_next = SLAVE_IDLE;
        end else if (penable) begin
          if (wait_cnt_reg == 4'd0) begin
            pready     = 1'b1;
            state_next = SLAVE_IDLE;
          end else begin
            wait_cnt_next = wait_cnt_reg - 4'd1;
          end
        end
      end
      default: state_next = SLAVE_IDLE;
    endcase
  end

  assign pslverr = pready && err_reg;
  assign mem_we  = pready && (state_reg == SLAVE_WRITE) && !err_reg;
  assign err_cnt = err_cnt_reg;

  always_comb begin
    prdata = '0;
    if (pready && (state_reg == SLAVE_READ) && !err_reg) begin
      prdata = mem[addr_reg];
    end
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state_reg    <= SLAVE_IDLE;
      wait_cnt_reg <= 4'd0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      err_reg      <= 1'b0;
      err_cnt_reg  <= 8'd0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (setup) begin
        addr_reg  <= paddr[IDX_W-1:0];
        wdata_reg <= pwdata;
        err_reg   <= ({1'b0, paddr} >= DEPTH_L);
      end
      if (pslverr && (err_cnt_reg != 8'hFF)) begin
        err_cnt_reg <= err_cnt_reg + 8'd1;
      end
    end
  end

  // Register file needs a full clear on reset, so it is kept in flops.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_we) begin
      mem[addr_reg] <= wdata_reg;
    end
  end

endmodule
